// File: rtl/pwm_controller_pkg.sv
// Shared constants and the duty compare used by the 16-pin PWM controller.
// Duty 0xFF is forced fully on; otherwise a 256-step counter can never reach 100 %.
package pwm_controller_pkg;

   localparam int unsigned              PWM_CNT_BITS        = 8;
   localparam int unsigned              PWM_CLK_DIV_DEFAULT = 13;
   localparam logic [7:0]               DUTY_FULL           = 8'hFF;

   function automatic logic pwm_level(input int unsigned step, input logic [7:0] duty);
      if (duty == DUTY_FULL) begin
         return 1'b1;
      end
      return (step < 32'(duty));
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler producing a one-clk tick every CLK_DIV clocks.
// The tick is decoded from the counter, so it is high during the counter's last state.
module pwm_tick_gen
   import pwm_controller_pkg::*;
#(
   parameter int unsigned CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_tick
);

   localparam int unsigned W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] r_presc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (r_presc == LAST) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   assign o_tick = (r_presc == LAST);

endmodule

// File: rtl/pwm_controller.sv
// Drives 16 pins from SPI control registers with one shared PWM waveform.
// Duty is shadowed and only updated on the period wrap, so a period never glitches.
module pwm_controller
   import pwm_controller_pkg::*;
#(
   parameter int unsigned CLK_DIV  = PWM_CLK_DIV_DEFAULT,
   parameter int unsigned CNT_BITS = PWM_CNT_BITS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] en_reg_out_7_0,
   input  logic [7:0] en_reg_out_15_8,
   input  logic [7:0] en_reg_pwm_7_0,
   input  logic [7:0] en_reg_pwm_15_8,
   input  logic [7:0] pwm_duty_cycle,
   output logic [7:0] out_7_0,
   output logic [7:0] out_15_8,
   output logic       period_start
);

   logic                w_tick;
   logic                w_wrap;
   logic                w_level;
   logic [15:0]         w_en_out;
   logic [15:0]         w_en_pwm;
   logic [15:0]         w_nxt;
   logic [CNT_BITS-1:0] r_step_cnt;
   logic [7:0]          r_duty_sh;
   logic [15:0]         r_out;
   logic                r_period_start;

   pwm_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .o_tick (w_tick)
   );

   assign w_wrap   = w_tick && (r_step_cnt == '1);
   assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   // PWM-mode pins follow the shared level, static pins are held high; en_out gates both.
   always_comb begin
      w_level = pwm_level(32'(r_step_cnt), r_duty_sh);
      w_nxt   = w_en_out & ((w_en_pwm & {16{w_level}}) | ~w_en_pwm);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step_cnt     <= '0;
         r_duty_sh      <= '0;
         r_out          <= '0;
         r_period_start <= 1'b0;
      end else begin
         if (w_tick) begin
            r_step_cnt <= r_step_cnt + 1'b1;
         end
         if (w_wrap) begin
            r_duty_sh <= pwm_duty_cycle;
         end
         r_period_start <= w_wrap;
         r_out          <= w_nxt;
      end
   end

   assign out_7_0      = r_out[7:0];
   assign out_15_8     = r_out[15:8];
   assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_controller.sv
// Scenario bench for pwm_controller: expected values are queued when stimulus is applied
// and popped when the corresponding output window has been observed.
module tb_pwm_controller;

   localparam int PERIOD = 13 * 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [7:0]  out_7_0;
   logic [7:0]  out_15_8;
   logic        period_start;
   logic [15:0] w_pins;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   pwm_controller #(
      .CLK_DIV  (13),
      .CNT_BITS (8)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out_7_0         (out_7_0),
      .out_15_8        (out_15_8),
      .period_start    (period_start)
   );

   always #50 clk = ~clk;

   assign w_pins = {out_15_8, out_7_0};

   task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
      {en_reg_out_15_8, en_reg_out_7_0} = eo;
      {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
   endtask

   task automatic wait_ps(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int k = 0; k < PERIOD + 20; k++) begin
         @(negedge clk);
         n++;
         if (period_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] e;
      rst_n = 1'b0;
      set_en(16'hFFFF, 16'hFFFF);
      pwm_duty_cycle = 8'hFF;
      repeat (10) @(negedge clk);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_cmp++;
      if ({16'h0, w_pins} !== e) begin
         n_err++; $display("FAIL reset_out: got %h expected %h", w_pins, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if ({31'h0, period_start} !== e) begin
         n_err++; $display("FAIL reset_period_start: got %b expected %0h", period_start, e);
      end
      rst_n = 1'b1;
      set_en(16'h0000, 16'h0000);
      pwm_duty_cycle = 8'h00;
   endtask

   task automatic test_static();
      logic [31:0] e;
      int          bad;
      @(negedge clk);
      set_en(16'hFFFF, 16'h0000);
      exp_q.push_back(32'hFFFF);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({16'h0, w_pins} !== e) begin
         n_err++; $display("FAIL static_on: got %h expected %h", w_pins, e);
      end
      exp_q.push_back(32'h0);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (w_pins !== 16'hFFFF) bad++;
      end
      e = exp_q.pop_front(); n_cmp++;
      if (bad !== e) begin
         n_err++; $display("FAIL static_hold: got %0d bad cycles expected %0d", bad, e);
      end
      set_en(16'hA5C3, 16'h0000);
      exp_q.push_back(32'hA5C3);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({16'h0, w_pins} !== e) begin
         n_err++; $display("FAIL static_pattern: got %h expected %h", w_pins, e);
      end
      set_en(16'h0000, 16'hFFFF);
      exp_q.push_back(32'h0000);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({16'h0, w_pins} !== e) begin
         n_err++; $display("FAIL en_out_gates_pwm: got %h expected %h", w_pins, e);
      end
      // Still in the first period after reset, so PWM pins see duty_sh=0.
      set_en(16'hFFFF, 16'h00FF);
      exp_q.push_back(32'hFF00);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({16'h0, w_pins} !== e) begin
         n_err++; $display("FAIL first_period_duty0: got %h expected %h", w_pins, e);
      end
   endtask

   task automatic test_duty50();
      logic [31:0] e;
      int          n, highs, first_low, ps_at, other;
      bit          ok;
      set_en(16'h0001, 16'h0001);
      pwm_duty_cycle = 8'h80;
      wait_ps(n, ok);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL duty50_wait: got no period_start in %0d clk expected one", n);
      end
      exp_q.push_back(32'd1664);
      exp_q.push_back(32'd1665);
      exp_q.push_back(32'd3328);
      exp_q.push_back(32'd0);
      highs = 0; first_low = 0; ps_at = 0; other = 0;
      for (int i = 1; i <= PERIOD; i++) begin
         @(negedge clk);
         if (out_7_0[0] === 1'b1) highs++;
         if (out_7_0[0] !== 1'b1 && first_low == 0) first_low = i;
         if (period_start === 1'b1 && ps_at == 0) ps_at = i;
         if (w_pins[15:1] !== 15'h0) other++;
      end
      e = exp_q.pop_front(); n_cmp++;
      if (highs !== e) begin
         n_err++; $display("FAIL duty50_high: got %0d expected %0d", highs, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (first_low !== e) begin
         n_err++; $display("FAIL duty50_first_low: got %0d expected %0d", first_low, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (ps_at !== e) begin
         n_err++; $display("FAIL duty50_spacing: got %0d expected %0d", ps_at, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (other !== e) begin
         n_err++; $display("FAIL duty50_other_pins: got %0d expected %0d", other, e);
      end
   endtask

   task automatic test_extremes();
      logic [31:0] e;
      int          n, cnt, ps;
      bit          ok;
      pwm_duty_cycle = 8'h00;
      wait_ps(n, ok);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL ext0_wait: got no period_start in %0d clk expected one", n);
      end
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd3);
      cnt = 0; ps = 0;
      for (int i = 1; i <= 3 * PERIOD; i++) begin
         @(negedge clk);
         if (out_7_0[0] !== 1'b0) cnt++;
         if (period_start === 1'b1) ps++;
      end
      e = exp_q.pop_front(); n_cmp++;
      if (cnt !== e) begin
         n_err++; $display("FAIL duty00_high: got %0d expected %0d", cnt, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (ps !== e) begin
         n_err++; $display("FAIL duty00_periods: got %0d expected %0d", ps, e);
      end
      pwm_duty_cycle = 8'hFF;
      wait_ps(n, ok);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL extff_wait: got no period_start in %0d clk expected one", n);
      end
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd3);
      cnt = 0; ps = 0;
      for (int i = 1; i <= 3 * PERIOD; i++) begin
         @(negedge clk);
         if (out_7_0[0] !== 1'b1) cnt++;
         if (period_start === 1'b1) ps++;
      end
      e = exp_q.pop_front(); n_cmp++;
      if (cnt !== e) begin
         n_err++; $display("FAIL dutyff_low: got %0d expected %0d", cnt, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (ps !== e) begin
         n_err++; $display("FAIL dutyff_periods: got %0d expected %0d", ps, e);
      end
   endtask

   task automatic test_mid_change();
      logic [31:0] e;
      int          n, h1, h2, tr;
      logic        prev;
      bit          ok;
      pwm_duty_cycle = 8'h40;
      wait_ps(n, ok);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL mid_wait: got no period_start in %0d clk expected one", n);
      end
      exp_q.push_back(32'd832);
      exp_q.push_back(32'd2496);
      exp_q.push_back(32'd3);
      h1 = 0; h2 = 0; tr = 0; prev = 1'b0;
      for (int i = 1; i <= 2 * PERIOD; i++) begin
         @(negedge clk);
         if (out_7_0[0] === 1'b1) begin
            if (i <= PERIOD) h1++;
            else h2++;
         end
         if (i > 1 && out_7_0[0] !== prev) tr++;
         prev = out_7_0[0];
         if (i == 1300) pwm_duty_cycle = 8'hC0;
      end
      e = exp_q.pop_front(); n_cmp++;
      if (h1 !== e) begin
         n_err++; $display("FAIL mid_current_period: got %0d high expected %0d", h1, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (h2 !== e) begin
         n_err++; $display("FAIL mid_next_period: got %0d high expected %0d", h2, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (tr !== e) begin
         n_err++; $display("FAIL mid_glitch: got %0d edges expected %0d", tr, e);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] e;
      int          n, p0_high, other_bad;
      set_en(16'hFFFF, 16'h0001);
      repeat (150 * 13) @(negedge clk);
      exp_q.push_back(32'hFFFF);
      e = exp_q.pop_front(); n_cmp++;
      if ({16'h0, w_pins} !== e) begin
         n_err++; $display("FAIL pre_reset_out: got %h expected %h", w_pins, e);
      end
      pwm_duty_cycle = 8'h80;
      #10 rst_n = 1'b0;
      #1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_cmp++;
      if ({16'h0, w_pins} !== e) begin
         n_err++; $display("FAIL async_reset_out: got %h expected %h", w_pins, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if ({31'h0, period_start} !== e) begin
         n_err++; $display("FAIL async_reset_ps: got %b expected %0h", period_start, e);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(32'd3328);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      n = 0; p0_high = 0; other_bad = 0;
      for (int k = 0; k < PERIOD + 20; k++) begin
         @(negedge clk);
         n++;
         if (period_start === 1'b1) break;
         if (out_7_0[0] !== 1'b0) p0_high++;
         if (w_pins[15:1] !== 15'h7FFF) other_bad++;
      end
      e = exp_q.pop_front(); n_cmp++;
      if (n !== e) begin
         n_err++; $display("FAIL post_reset_first_ps: got %0d clk expected %0d", n, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (p0_high !== e) begin
         n_err++; $display("FAIL post_reset_duty0: got %0d high expected %0d", p0_high, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (other_bad !== e) begin
         n_err++; $display("FAIL post_reset_static: got %0d bad expected %0d", other_bad, e);
      end
      exp_q.push_back(32'h1);
      @(negedge clk);
      e = exp_q.pop_front(); n_cmp++;
      if ({31'h0, out_7_0[0]} !== e) begin
         n_err++; $display("FAIL post_reset_new_duty: got %b expected %0h", out_7_0[0], e);
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_duty50();
      test_extremes();
      test_mid_change();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
